glyph_sequencer: RTL

GLYPH_SEQUENCER -- requirements
Module: glyph_sequencer

---
 rtl/glyph_sequencer_if.sv | 9 +
 rtl/glyph_sequencer.sv | 117 +++++++++++
 2 files changed

// File: rtl/glyph_sequencer_if.sv
// glyph_sequencer_if: column stream from the sequencer to the display consumer
interface glyph_sequencer_if;
  logic [29:0] col_data;
  logic col_valid;
  logic col_ready;
  logic col_last;
  modport master (output col_data, col_valid, col_last, input col_ready);
  modport slave (input col_data, col_valid, col_last, output col_ready);
endinterface

// File: rtl/glyph_sequencer.sv
// glyph_sequencer: plays a buffered ASCII message as a paced stream of glyph columns
module glyph_sequencer #(
  parameter int MSG_LEN = 8,
  parameter int TICK_DIV = 25000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wr_en,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_char,
  input  logic [3:0] msg_len,
  input  logic loop_en,
  input  logic start,
  input  logic stop,
  output logic [7:0] char_code,
  input  logic [119:0] glyph_cols,
  glyph_sequencer_if.master col,
  output logic busy,
  output logic done
);
  typedef enum logic [1:0] {IDLE, FETCH, EMIT, GAP} state_t;
  state_t state;
  logic [7:0] buffer [MSG_LEN];
  logic [119:0] glyph, gl;
  logic [3:0] len;
  logic loop;
  logic [2:0] ci, col_idx, nci, ncol;
  logic [31:0] tick;
  logic [29:0] col_data;
  logic col_valid, col_last;
  logic last_char, fin, adv;
  function automatic logic [29:0] pick(input logic [119:0] g, input logic [2:0] c);
    return c >= 3'd4 ? 30'd0 : g[30*int'(c) +: 30];
  endfunction
  assign col.col_data = col_data;
  assign col.col_valid = col_valid;
  assign col.col_last = col_last;
  assign gl = char_code inside {8'd65, 8'd68, 8'd69, 8'd71, 8'd73, 8'd76, 8'd80, 8'd82, 8'd84, 8'd88, 8'd89} ? glyph_cols : '0;
  assign last_char = {1'b0, ci} == len - 4'd1;
  assign nci = last_char ? 3'd0 : ci + 3'd1;
  assign ncol = col_idx + 3'd1;
  assign fin = col_last && !loop;
  // end of the inter-column pause; with TICK_DIV=1 the pause collapses onto the acceptance itself
  assign adv = (state == GAP && tick == 32'(TICK_DIV - 2)) ||
               (state == EMIT && col.col_ready && !fin && TICK_DIV == 1);
  // playback state machine, column register and message buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      for (int i = 0; i < MSG_LEN; i++) buffer[i] <= '0;
      glyph <= '0;
      len <= '0;
      loop <= 1'b0;
      ci <= '0;
      col_idx <= '0;
      tick <= '0;
      char_code <= '0;
      col_data <= '0;
      col_valid <= 1'b0;
      col_last <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (wr_en && !busy) buffer[wr_addr] <= wr_char;
      if (stop) begin
        state <= IDLE;
        busy <= 1'b0;
        col_valid <= 1'b0;
        col_last <= 1'b0;
      end else if (adv) begin
        if (col_idx == 3'd4) begin
          state <= FETCH;
          col_idx <= '0;
          ci <= nci;
          char_code <= buffer[nci];
          col_valid <= 1'b0;
          col_last <= 1'b0;
        end else begin
          state <= EMIT;
          col_idx <= ncol;
          col_data <= pick(glyph, ncol);
          col_valid <= 1'b1;
          col_last <= last_char && ncol == 3'd4;
        end
      end else begin
        case (state)
          IDLE: if (start && msg_len != 4'd0 && msg_len <= 4'(MSG_LEN)) begin
            state <= FETCH;
            len <= msg_len;
            loop <= loop_en;
            ci <= '0;
            col_idx <= '0;
            char_code <= buffer[3'd0];
            busy <= 1'b1;
          end
          FETCH: begin
            glyph <= gl;
            col_data <= gl[29:0];
            col_valid <= 1'b1;
            state <= EMIT;
          end
          EMIT: if (col.col_ready) begin
            col_valid <= 1'b0;
            col_last <= 1'b0;
            tick <= '0;
            state <= fin ? IDLE : GAP;
            busy <= !fin;
            done <= fin;
          end
          GAP: tick <= tick + 32'd1;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
